// File: rtl/uart_rx_frame_pkg.sv
// Shared UART definitions: receiver state encoding, parity encodings and
// the baud/character-length helpers used by the RX and TX sides.
package uart_rx_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRKWAIT
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic int calc_bps(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int calc_char_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Receiver-side bundle: serial line in, received word and status out.
// The slave modport is the receiver, the master modport is the line driver / consumer.
interface uart_rx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic                 rs232_rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_state;
    logic                 rx_done;
    logic                 parity_err;
    logic                 frame_err;
    logic                 frame_idle;

    modport master (
        output rs232_rx,
        input  rx_data, rx_state, rx_done, parity_err, frame_err, frame_idle
    );

    modport slave (
        input  rs232_rx,
        output rx_data, rx_state, rx_done, parity_err, frame_err, frame_idle
    );
endinterface

// File: rtl/uart_rx_frame_baud_tick.sv
// Restartable baud counter 0..BPS_PARAM-1 with three mid-bit sample strobes
// and a bit-end strobe; held at zero while disabled.
module uart_rx_frame_baud_tick #(
    parameter int BPS_PARAM = 16
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic restart,
    input  logic enable,
    output logic samp_early,
    output logic samp_mid,
    output logic samp_late,
    output logic bit_end
);
    localparam int CNT_W = $clog2(BPS_PARAM);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BPS_PARAM - 1);
    localparam logic [CNT_W-1:0] CNT_EARLY = CNT_W'(BPS_PARAM / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(BPS_PARAM / 2);
    localparam logic [CNT_W-1:0] CNT_LATE  = CNT_W'(BPS_PARAM / 2 + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt <= '0;
        end else if (restart || !enable || cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign samp_early = enable && (cnt == CNT_EARLY);
    assign samp_mid   = enable && (cnt == CNT_MID);
    assign samp_late  = enable && (cnt == CNT_LATE);
    assign bit_end    = enable && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver with majority-vote sampling, parity/frame errors and break handling.
// Optional Modbus RTU t3.5 idle marker on frame_idle when UART_RX_IDLE_EN is defined.
module uart_rx_frame
    import uart_rx_frame_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic           clk_in,
    input  logic           rst_n_in,
    uart_rx_frame_if.slave rx_if
);
    localparam int BPS_PARAM = calc_bps(CLK_FREQ, BAUD_RATE);
    localparam int CHAR_BITS = calc_char_bits(DATA_BITS, PARITY, STOP_BITS);
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS);
    localparam logic [3:0] LAST_BIT  = 4'(CHAR_BITS - 1);

    rx_state_t            state;
    logic [2:0]           sync_q;
    logic                 line;
    logic                 start_det;
    logic                 samp_early, samp_mid, samp_late, bit_end;
    logic                 s_early, s_mid, maj;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 zero_q;

    // sync_q[2] holds the previous synchronised value for edge detection
    assign line      = sync_q[1];
    assign start_det = (state == ST_IDLE) && sync_q[2] && !line;
    assign maj       = (s_early & s_mid) | (s_early & line) | (s_mid & line);

    uart_rx_frame_baud_tick #(.BPS_PARAM(BPS_PARAM)) u_baud (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .restart    (start_det),
        .enable     (state != ST_IDLE),
        .samp_early (samp_early),
        .samp_mid   (samp_mid),
        .samp_late  (samp_late),
        .bit_end    (bit_end)
    );

    // bit_cnt is the position within the character: 0 start, 1..DATA_BITS data, then parity/stop
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync_q  <= 3'b111;
            s_early <= 1'b0;
            s_mid   <= 1'b0;
            bit_cnt <= '0;
        end else begin
            sync_q <= {sync_q[1:0], rx_if.rs232_rx};
            if (samp_early) s_early <= line;
            if (samp_mid)   s_mid   <= line;
            if (start_det)    bit_cnt <= '0;
            else if (bit_end) bit_cnt <= bit_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state            <= ST_IDLE;
            shreg            <= '0;
            zero_q           <= 1'b0;
            rx_if.rx_data    <= '0;
            rx_if.rx_state   <= 1'b0;
            rx_if.rx_done    <= 1'b0;
            rx_if.parity_err <= 1'b0;
            rx_if.frame_err  <= 1'b0;
        end else begin
            rx_if.rx_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    rx_if.rx_state <= start_det;
                    if (start_det) state <= ST_START;
                end
                ST_START: if (samp_late) begin
                    if (maj) begin
                        state          <= ST_IDLE;
                        rx_if.rx_state <= 1'b0;
                    end else begin
                        state            <= ST_DATA;
                        zero_q           <= 1'b1;
                        rx_if.parity_err <= 1'b0;
                        rx_if.frame_err  <= 1'b0;
                    end
                end
                ST_DATA: if (samp_late) begin
                    shreg <= {maj, shreg[DATA_BITS-1:1]};
                    if (maj) zero_q <= 1'b0;
                    if (bit_cnt == LAST_DATA)
                        state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                end
                ST_PARITY: if (samp_late) begin
                    if (maj) zero_q <= 1'b0;
                    rx_if.parity_err <= (PARITY == PAR_ODD) ? ~(^shreg ^ maj) : (^shreg ^ maj);
                    state            <= ST_STOP;
                end
                ST_STOP: if (samp_late) begin
                    if (!maj) rx_if.frame_err <= 1'b1;
                    if (maj)  zero_q <= 1'b0;
                    // leaving at mid-bit keeps back-to-back start edges visible
                    if (bit_cnt == LAST_BIT) begin
                        rx_if.rx_done <= 1'b1;
                        rx_if.rx_data <= shreg;
                        state         <= (zero_q && !maj) ? ST_BRKWAIT : ST_IDLE;
                    end
                end
                ST_BRKWAIT: begin
                    rx_if.rx_state <= 1'b0;
                    if (line) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef UART_RX_IDLE_EN
    localparam int T35    = (35 * CHAR_BITS * BPS_PARAM) / 10;
    localparam int IDLE_W = $clog2(T35 + 1);
    localparam logic [IDLE_W-1:0] T35_CNT = IDLE_W'(T35);

    logic [IDLE_W-1:0] idle_cnt;
    logic              idle_armed;

    // the rx_done cycle itself counts as the first idle clock
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            idle_cnt         <= '0;
            idle_armed       <= 1'b0;
            rx_if.frame_idle <= 1'b0;
        end else begin
            rx_if.frame_idle <= 1'b0;
            if (rx_if.rx_done) begin
                idle_cnt   <= IDLE_W'(1);
                idle_armed <= 1'b1;
            end else if (start_det) begin
                idle_cnt <= '0;
            end else if (state == ST_IDLE && idle_cnt != T35_CNT) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
                if (idle_armed && idle_cnt == T35_CNT - IDLE_W'(1)) begin
                    rx_if.frame_idle <= 1'b1;
                    idle_armed       <= 1'b0;
                end
            end
        end
    end
`else
    assign rx_if.frame_idle = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: 8N1, 8E1 and 7O2 instances at 16 clocks/bit.
// Idle-marker checks are active when UART_RX_IDLE_EN is defined.
module tb_uart_rx_frame;
    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic clk_in;
    logic rst_n_in;
    int   total;
    int   bad;
    int   cyc;
    exp_t exp_q[3][$];
    int   last_done[3];
    int   idle_pulses[3];
    logic st_chk[3];
    int   t35_tab[3];
    int   n0;

    uart_rx_frame_if #(.DATA_BITS(8)) if_a ();
    uart_rx_frame_if #(.DATA_BITS(8)) if_b ();
    uart_rx_frame_if #(.DATA_BITS(7)) if_c ();

    uart_rx_frame #(.CLK_FREQ(160000), .BAUD_RATE(10000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
        dut_a (.clk_in(clk_in), .rst_n_in(rst_n_in), .rx_if(if_a));
    uart_rx_frame #(.CLK_FREQ(160000), .BAUD_RATE(10000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
        dut_b (.clk_in(clk_in), .rst_n_in(rst_n_in), .rx_if(if_b));
    uart_rx_frame #(.CLK_FREQ(160000), .BAUD_RATE(10000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2))
        dut_c (.clk_in(clk_in), .rst_n_in(rst_n_in), .rx_if(if_c));

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_char(input int k, input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.data = d;
        e.perr = pe;
        e.ferr = fe;
        exp_q[k].push_back(e);
    endtask

    task automatic set_line(input int k, input logic v);
        case (k)
            0:       if_a.rs232_rx = v;
            1:       if_b.rs232_rx = v;
            default: if_c.rs232_rx = v;
        endcase
    endtask

    // bits[0] goes on the line first; 16 clocks per bit
    task automatic send_bits(input int k, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            set_line(k, bits[i]);
            repeat (16) @(negedge clk_in);
        end
        set_line(k, 1'b1);
    endtask

    task automatic mon(input int k, input logic done, input logic st, input logic pe,
                       input logic fe, input logic fi, input logic [7:0] d);
        exp_t e;
        if (st_chk[k]) begin
            chk($sformatf("rx_state_fall_%0d", k), {31'b0, st}, 32'd0);
            st_chk[k] = 1'b0;
        end
        if (done) begin
            chk($sformatf("rx_state_at_done_%0d", k), {31'b0, st}, 32'd1);
            if (exp_q[k].size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rx_done_%0d actual data=%0h required no character", k, d);
            end else begin
                e = exp_q[k].pop_front();
                chk($sformatf("rx_data_%0d", k), {24'b0, d}, {24'b0, e.data});
                chk($sformatf("parity_err_%0d", k), {31'b0, pe}, {31'b0, e.perr});
                chk($sformatf("frame_err_%0d", k), {31'b0, fe}, {31'b0, e.ferr});
            end
            st_chk[k]    = 1'b1;
            last_done[k] = cyc;
        end
        if (fi) begin
            idle_pulses[k]++;
            chk($sformatf("frame_idle_delay_%0d", k), cyc - last_done[k], t35_tab[k]);
        end
    endtask

    always @(negedge clk_in) begin
        mon(0, if_a.rx_done, if_a.rx_state, if_a.parity_err, if_a.frame_err, if_a.frame_idle, if_a.rx_data);
        mon(1, if_b.rx_done, if_b.rx_state, if_b.parity_err, if_b.frame_err, if_b.frame_idle, if_b.rx_data);
        mon(2, if_c.rx_done, if_c.rx_state, if_c.parity_err, if_c.frame_err, if_c.frame_idle, {1'b0, if_c.rx_data});
    end

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        t35_tab = '{560, 616, 616};
        for (int k = 0; k < 3; k++) begin
            last_done[k]   = 0;
            idle_pulses[k] = 0;
            st_chk[k]      = 1'b0;
        end
        if_a.rs232_rx = 1'b1;
        if_b.rs232_rx = 1'b1;
        if_c.rs232_rx = 1'b1;
        rst_n_in = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("reset_rx_data", {24'b0, if_a.rx_data}, 32'd0);
        chk("reset_rx_state", {31'b0, if_a.rx_state}, 32'd0);
        chk("reset_rx_done", {31'b0, if_a.rx_done}, 32'd0);
        chk("reset_flags", {30'b0, if_a.parity_err, if_a.frame_err}, 32'd0);
        chk("reset_frame_idle", {31'b0, if_a.frame_idle}, 32'd0);
        rst_n_in = 1'b1;
        repeat (5) @(negedge clk_in);

        // 8N1 0xA5
        expect_char(0, 8'hA5, 1'b0, 1'b0);
        send_bits(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10);
        repeat (32) @(negedge clk_in);

        // 8E1 0x03: wrong parity bit, then correct one
        expect_char(1, 8'h03, 1'b1, 1'b0);
        send_bits(1, {5'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
        expect_char(1, 8'h03, 1'b0, 1'b0);
        send_bits(1, {5'b0, 1'b1, 1'b0, 8'h03, 1'b0}, 11);
        repeat (32) @(negedge clk_in);

        // 5-clock glitch is a false start
        set_line(0, 1'b0);
        repeat (5) @(negedge clk_in);
        set_line(0, 1'b1);
        repeat (40) @(negedge clk_in);
        chk("glitch_rx_state", {31'b0, if_a.rx_state}, 32'd0);

        // 7O2 0x55, odd parity bit 1, second stop bit 0
        expect_char(2, 8'h55, 1'b0, 1'b1);
        send_bits(2, {5'b0, 1'b0, 1'b1, 1'b1, 7'h55, 1'b0}, 11);
        repeat (32) @(negedge clk_in);

        // break of 20 bit-times: one all-zero character, odd parity also fails
        expect_char(2, 8'h00, 1'b1, 1'b1);
        set_line(2, 1'b0);
        repeat (320) @(negedge clk_in);
        chk("break_rx_state", {31'b0, if_c.rx_state}, 32'd0);
        set_line(2, 1'b1);
        repeat (48) @(negedge clk_in);

        // back-to-back characters with no idle
        expect_char(0, 8'h11, 1'b0, 1'b0);
        expect_char(0, 8'h22, 1'b0, 1'b0);
        send_bits(0, {6'b0, 1'b1, 8'h11, 1'b0}, 10);
        send_bits(0, {6'b0, 1'b1, 8'h22, 1'b0}, 10);
        repeat (32) @(negedge clk_in);

        // reset in the middle of a character
        set_line(0, 1'b0);
        repeat (40) @(negedge clk_in);
        rst_n_in = 1'b0;
        @(negedge clk_in);
        chk("midreset_rx_data", {24'b0, if_a.rx_data}, 32'd0);
        chk("midreset_rx_state", {31'b0, if_a.rx_state}, 32'd0);
        chk("midreset_flags", {30'b0, if_a.parity_err, if_a.frame_err}, 32'd0);
        set_line(0, 1'b1);
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (5) @(negedge clk_in);
        expect_char(0, 8'h3C, 1'b0, 1'b0);
        send_bits(0, {6'b0, 1'b1, 8'h3C, 1'b0}, 10);

`ifdef UART_RX_IDLE_EN
        n0 = idle_pulses[0];
        expect_char(0, 8'h5A, 1'b0, 1'b0);
        send_bits(0, {6'b0, 1'b1, 8'h5A, 1'b0}, 10);
        repeat (700) @(negedge clk_in);
        chk("idle_pulse_after_gap", idle_pulses[0] - n0, 32'd1);
        expect_char(0, 8'h6B, 1'b0, 1'b0);
        send_bits(0, {6'b0, 1'b1, 8'h6B, 1'b0}, 10);
        repeat (292) @(negedge clk_in);
        expect_char(0, 8'h7C, 1'b0, 1'b0);
        send_bits(0, {6'b0, 1'b1, 8'h7C, 1'b0}, 10);
        chk("idle_no_pulse_short_gap", idle_pulses[0] - n0, 32'd1);
        repeat (700) @(negedge clk_in);
        chk("idle_pulse_final", idle_pulses[0] - n0, 32'd2);
`else
        repeat (700) @(negedge clk_in);
        chk("frame_idle_tied_low", idle_pulses[0] + idle_pulses[1] + idle_pulses[2], 32'd0);
`endif

        repeat (16) @(negedge clk_in);
        chk("queue_left_a", exp_q[0].size(), 32'd0);
        chk("queue_left_b", exp_q[1].size(), 32'd0);
        chk("queue_left_c", exp_q[2].size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
